gmii_rx_framer: RTL

Receive-side framer between the GMII PHY pins (already in the `lcl_clk` domain) and `ingress_frame_process`. Strips preamble and SFD, detects frame boundaries from `gmii_rx_dv`, and emits the sof/valid/eof byte stream that ingress frame processing consumes. Flags PHY receive errors per frame and keeps saturating framing-error statistics.

---
 rtl/ethernet_pkg.sv | 26 ++
 rtl/sat_counter.sv | 31 +++
 rtl/gmii_rx_framer.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/ethernet_pkg.sv
// ============================================================================
// Module  : ethernet_pkg
// Brief   : Shared Ethernet constants and types for the GMII receive path.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package ethernet_pkg;

    localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0] SFD_BYTE      = 8'hD5;

    // Preamble counter width; the count saturates at its all-ones value.
    localparam int         PRE_CNT_W     = 4;
    localparam logic [PRE_CNT_W-1:0] PRE_CNT_MAX = '1;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PREAMBLE = 2'd1,
        ST_DATA     = 2'd2,
        ST_DROP     = 2'd3
    } gmii_rx_state_t;

endpackage : ethernet_pkg

`default_nettype wire

// File: rtl/sat_counter.sv
// ============================================================================
// Module  : sat_counter
// Brief   : Statistics counter that increments on inc and holds at all-ones.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (inc && (r_count != {WIDTH{1'b1}})) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign count = r_count;

endmodule : sat_counter

`default_nettype wire

// File: rtl/gmii_rx_framer.sv
// ============================================================================
// Module  : gmii_rx_framer
// Brief   : GMII receive framer; strips preamble/SFD, emits sof/valid/eof stream.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module gmii_rx_framer
    import ethernet_pkg::*;
#(
    parameter int MIN_PREAMBLE_BYTES = 1,
    parameter int STATS_WIDTH        = 32
) (
    input  logic                   lcl_clk,
    input  logic                   reset_n,
    input  logic                   gmii_rx_dv,
    input  logic                   gmii_rx_er,
    input  logic [7:0]             gmii_rxd,
    output logic                   o_sof,
    output logic                   o_valid,
    output logic [7:0]             ov_dout,
    output logic                   o_eof,
    output logic                   o_rx_error,
    output logic [STATS_WIDTH-1:0] ov_frames,
    output logic [STATS_WIDTH-1:0] ov_preamble_errors,
    output logic [STATS_WIDTH-1:0] ov_rx_er_frames
);

    gmii_rx_state_t       r_state;
    logic [PRE_CNT_W-1:0] r_pre_cnt;
    logic                 r_err_flag;
    logic                 r_sof;
    logic                 r_valid;
    logic [7:0]           r_dout;
    logic                 r_eof;
    logic                 r_rx_error;
    logic                 r_pre_err;

    logic                 w_pre_ok;
    logic                 w_rx_er_frame;

    assign w_pre_ok      = (int'(r_pre_cnt) >= MIN_PREAMBLE_BYTES);
    assign w_rx_er_frame = r_eof & r_rx_error;

    always_ff @(posedge lcl_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_IDLE;
            r_pre_cnt  <= '0;
            r_err_flag <= 1'b0;
            r_sof      <= 1'b0;
            r_valid    <= 1'b0;
            r_dout     <= 8'h00;
            r_eof      <= 1'b0;
            r_rx_error <= 1'b0;
            r_pre_err  <= 1'b0;
        end else begin
            r_sof      <= 1'b0;
            r_valid    <= 1'b0;
            r_eof      <= 1'b0;
            r_rx_error <= 1'b0;
            r_pre_err  <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (gmii_rx_dv) begin
                        if (!gmii_rx_er && (gmii_rxd == PREAMBLE_BYTE)) begin
                            r_state   <= ST_PREAMBLE;
                            r_pre_cnt <= PRE_CNT_W'(1);
                        end else begin
                            r_state   <= ST_DROP;
                            r_pre_err <= 1'b1;
                        end
                    end
                end

                ST_PREAMBLE: begin
                    if (!gmii_rx_dv) begin
                        r_state   <= ST_IDLE;
                        r_pre_err <= 1'b1;
                    end else if (gmii_rx_er) begin
                        r_state   <= ST_DROP;
                        r_pre_err <= 1'b1;
                    end else if (gmii_rxd == PREAMBLE_BYTE) begin
                        if (r_pre_cnt != PRE_CNT_MAX) begin
                            r_pre_cnt <= r_pre_cnt + 1'b1;
                        end
                    end else if ((gmii_rxd == SFD_BYTE) && w_pre_ok) begin
                        r_state    <= ST_DATA;
                        r_sof      <= 1'b1;
                        r_err_flag <= 1'b0;
                    end else begin
                        r_state   <= ST_DROP;
                        r_pre_err <= 1'b1;
                    end
                end

                ST_DATA: begin
                    if (gmii_rx_dv) begin
                        r_valid <= 1'b1;
                        r_dout  <= gmii_rxd;
                        if (gmii_rx_er) begin
                            r_err_flag <= 1'b1;
                        end
                    end else begin
                        r_eof      <= 1'b1;
                        r_rx_error <= r_err_flag;
                        r_state    <= ST_IDLE;
                    end
                end

                ST_DROP: begin
                    if (!gmii_rx_dv) begin
                        r_state <= ST_IDLE;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_sof      = r_sof;
    assign o_valid    = r_valid;
    assign ov_dout    = r_dout;
    assign o_eof      = r_eof;
    assign o_rx_error = r_rx_error;

    // Counters trigger off the registered pulses, so they lag the event by a cycle.
    sat_counter #(.WIDTH(STATS_WIDTH)) u_frames_cnt (
        .clock   (lcl_clk),
        .reset_n (reset_n),
        .inc     (r_eof),
        .count   (ov_frames)
    );

    sat_counter #(.WIDTH(STATS_WIDTH)) u_pre_err_cnt (
        .clock   (lcl_clk),
        .reset_n (reset_n),
        .inc     (r_pre_err),
        .count   (ov_preamble_errors)
    );

    sat_counter #(.WIDTH(STATS_WIDTH)) u_rx_er_cnt (
        .clock   (lcl_clk),
        .reset_n (reset_n),
        .inc     (w_rx_er_frame),
        .count   (ov_rx_er_frames)
    );

endmodule : gmii_rx_framer

`default_nettype wire
